riscv_wb_arbiter: RTL and testbench

RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

---
 rtl/riscv_wb_pkg.sv | 36 +++
 rtl/riscv_rr_arbiter4.sv | 40 ++++
 rtl/riscv_wb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_riscv_wb_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the writeback arbiter: source encoding, widths and
// the same-cycle conflict priority between sources.
package riscv_wb_pkg;

  typedef enum logic [1:0] {
    SrcExec   = 2'd0,
    SrcMem    = 2'd1,
    SrcCsr    = 2'd2,
    SrcMuldiv = 2'd3
  } wb_src_e;

  localparam int unsigned NUM_WB_SRC = 4;
  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 1 << REG_IDX_W;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      xlen_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t idx;
    xlen_t    value;
  } wb_entry_t;

  // Higher rank wins when two sources capture the same destination in one cycle.
  function automatic logic [1:0] src_rank(input logic [1:0] src);
    case (src)
      SrcMem:    return 2'd3;
      SrcMuldiv: return 2'd2;
      SrcCsr:    return 2'd1;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_rr_arbiter4.sv
// Four-way round-robin arbiter with a registered last-grant pointer and one-hot grant.
// Search starts at the source after the last one granted.
module riscv_rr_arbiter4
  import riscv_wb_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_WB_SRC-1:0] req_i,
  output logic [NUM_WB_SRC-1:0] gnt_o
);

  logic [1:0] last_q, last_d;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_WB_SRC; k++) begin
      cand = last_q + 2'(k);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        last_d      = cand;
        found       = 1'b1;
      end
    end
  end

  // Resetting to the last source makes exec the first candidate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= SrcMuldiv;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Register-file writeback arbiter: one single-entry buffer per source, round-robin drain
// of one write per cycle, and newest-wins invalidation of stale buffered writes.
module riscv_wb_arbiter
  import riscv_wb_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 wb_exec_valid_i,
  input  logic [REG_IDX_W-1:0] wb_exec_idx_i,
  input  logic [XLEN-1:0]      wb_exec_value_i,
  input  logic                 wb_exec_squash_i,
  output logic                 wb_exec_accept_o,
  input  logic                 wb_mem_valid_i,
  input  logic [REG_IDX_W-1:0] wb_mem_idx_i,
  input  logic [XLEN-1:0]      wb_mem_value_i,
  input  logic                 wb_mem_squash_i,
  output logic                 wb_mem_accept_o,
  input  logic                 wb_csr_valid_i,
  input  logic [REG_IDX_W-1:0] wb_csr_idx_i,
  input  logic [XLEN-1:0]      wb_csr_value_i,
  input  logic                 wb_csr_squash_i,
  output logic                 wb_csr_accept_o,
  input  logic                 wb_muldiv_valid_i,
  input  logic [REG_IDX_W-1:0] wb_muldiv_idx_i,
  input  logic [XLEN-1:0]      wb_muldiv_value_i,
  input  logic                 wb_muldiv_squash_i,
  output logic                 wb_muldiv_accept_o,
  output logic                 rf_wr_en_o,
  output logic [REG_IDX_W-1:0] rf_wr_idx_o,
  output logic [XLEN-1:0]      rf_wr_value_o,
  output logic [NUM_REGS-1:0]  pending_mask_o,
  output logic                 wb_stall_o
);

  logic [NUM_WB_SRC-1:0] req_valid, req_squash;
  reg_idx_t              req_idx   [NUM_WB_SRC];
  xlen_t                 req_value [NUM_WB_SRC];

  wb_entry_t             ent_q [NUM_WB_SRC];
  wb_entry_t             ent_d [NUM_WB_SRC];
  logic [NUM_WB_SRC-1:0] ent_valid, gnt, accept, cap_raw, cap, kill;

  logic                  rf_wr_en_q;
  reg_idx_t              rf_wr_idx_q, gnt_idx;
  xlen_t                 rf_wr_value_q, gnt_value;

  assign req_valid  = {wb_muldiv_valid_i, wb_csr_valid_i, wb_mem_valid_i, wb_exec_valid_i};
  assign req_squash = {wb_muldiv_squash_i, wb_csr_squash_i, wb_mem_squash_i, wb_exec_squash_i};

  assign req_idx[SrcExec]     = wb_exec_idx_i;
  assign req_idx[SrcMem]      = wb_mem_idx_i;
  assign req_idx[SrcCsr]      = wb_csr_idx_i;
  assign req_idx[SrcMuldiv]   = wb_muldiv_idx_i;
  assign req_value[SrcExec]   = wb_exec_value_i;
  assign req_value[SrcMem]    = wb_mem_value_i;
  assign req_value[SrcCsr]    = wb_csr_value_i;
  assign req_value[SrcMuldiv] = wb_muldiv_value_i;

  always_comb begin
    ent_valid = '0;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      ent_valid[s] = ent_q[s].valid;
    end
  end

  riscv_rr_arbiter4 u_rr (
    .clk_i (CLK),
    .rst_i (RST_N),
    .req_i (ent_valid),
    .gnt_o (gnt)
  );

  // A slot frees up in the same cycle it is granted, so accept depends on the grant.
  always_comb begin
    accept = '0;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      accept[s] = ~RST_N & (~ent_q[s].valid | gnt[s]);
    end
  end

  assign wb_exec_accept_o   = accept[SrcExec];
  assign wb_mem_accept_o    = accept[SrcMem];
  assign wb_csr_accept_o    = accept[SrcCsr];
  assign wb_muldiv_accept_o = accept[SrcMuldiv];

  // Squashed and x0 requests are accepted but never stored; same-idx losers are dropped.
  always_comb begin
    cap_raw = '0;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      cap_raw[s] = req_valid[s] & accept[s] & ~req_squash[s] & (req_idx[s] != '0);
    end
    cap = cap_raw;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      for (int t = 0; t < NUM_WB_SRC; t++) begin
        if ((s != t) && cap_raw[s] && cap_raw[t] && (req_idx[s] == req_idx[t]) &&
            (src_rank(2'(t)) > src_rank(2'(s)))) begin
          cap[s] = 1'b0;
        end
      end
    end
  end

  // A held entry is stale once another source captures a newer write to the same register.
  always_comb begin
    kill = '0;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      for (int t = 0; t < NUM_WB_SRC; t++) begin
        if ((s != t) && cap[t] && ent_q[s].valid && !gnt[s] &&
            (req_idx[t] == ent_q[s].idx)) begin
          kill[s] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      ent_d[s] = ent_q[s];
      if (gnt[s] || kill[s]) begin
        ent_d[s].valid = 1'b0;
      end
      if (cap[s]) begin
        ent_d[s].valid = 1'b1;
        ent_d[s].idx   = req_idx[s];
        ent_d[s].value = req_value[s];
      end
    end
  end

  always_comb begin
    gnt_idx   = '0;
    gnt_value = '0;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      if (gnt[s]) begin
        gnt_idx   = ent_q[s].idx;
        gnt_value = ent_q[s].value;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      for (int s = 0; s < NUM_WB_SRC; s++) begin
        ent_q[s] <= '0;
      end
      rf_wr_en_q    <= 1'b0;
      rf_wr_idx_q   <= '0;
      rf_wr_value_q <= '0;
    end else begin
      for (int s = 0; s < NUM_WB_SRC; s++) begin
        ent_q[s] <= ent_d[s];
      end
      rf_wr_en_q <= |gnt;
      if (|gnt) begin
        rf_wr_idx_q   <= gnt_idx;
        rf_wr_value_q <= gnt_value;
      end
    end
  end

  assign rf_wr_en_o    = rf_wr_en_q;
  assign rf_wr_idx_o   = rf_wr_idx_q;
  assign rf_wr_value_o = rf_wr_value_q;

  always_comb begin
    pending_mask_o = '0;
    for (int s = 0; s < NUM_WB_SRC; s++) begin
      if (ent_q[s].valid) begin
        pending_mask_o[ent_q[s].idx] = 1'b1;
      end
    end
    pending_mask_o[0] = 1'b0;
  end

  assign wb_stall_o = |(ent_valid & ~gnt);

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter: hand-computed writeback order, latency,
// invalidation, conflict priority and reset behaviour.
module tb_riscv_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [3:0]  v, sq;
  logic [4:0]  ix [4];
  logic [31:0] vl [4];
  logic        acc_exec, acc_mem, acc_csr, acc_muldiv;
  logic        rf_wr_en_o;
  logic [4:0]  rf_wr_idx_o;
  logic [31:0] rf_wr_value_o;
  logic [31:0] pending_mask_o;
  logic        wb_stall_o;
  logic [3:0]  acc;

  int n_vec = 0;
  int n_err = 0;

  assign acc = {acc_muldiv, acc_csr, acc_mem, acc_exec};

  riscv_wb_arbiter dut (
    .CLK                (CLK),
    .RST_N              (RST_N),
    .wb_exec_valid_i    (v[0]),
    .wb_exec_idx_i      (ix[0]),
    .wb_exec_value_i    (vl[0]),
    .wb_exec_squash_i   (sq[0]),
    .wb_exec_accept_o   (acc_exec),
    .wb_mem_valid_i     (v[1]),
    .wb_mem_idx_i       (ix[1]),
    .wb_mem_value_i     (vl[1]),
    .wb_mem_squash_i    (sq[1]),
    .wb_mem_accept_o    (acc_mem),
    .wb_csr_valid_i     (v[2]),
    .wb_csr_idx_i       (ix[2]),
    .wb_csr_value_i     (vl[2]),
    .wb_csr_squash_i    (sq[2]),
    .wb_csr_accept_o    (acc_csr),
    .wb_muldiv_valid_i  (v[3]),
    .wb_muldiv_idx_i    (ix[3]),
    .wb_muldiv_value_i  (vl[3]),
    .wb_muldiv_squash_i (sq[3]),
    .wb_muldiv_accept_o (acc_muldiv),
    .rf_wr_en_o         (rf_wr_en_o),
    .rf_wr_idx_o        (rf_wr_idx_o),
    .rf_wr_value_o      (rf_wr_value_o),
    .pending_mask_o     (pending_mask_o),
    .wb_stall_o         (wb_stall_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    v  = '0;
    sq = '0;
    for (int i = 0; i < 4; i++) begin
      ix[i] = '0;
      vl[i] = '0;
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic [4:0] idx, input logic [31:0] val,
                       input logic squash);
    v[s]  = 1'b1;
    ix[s] = idx;
    vl[s] = val;
    sq[s] = squash;
  endtask

  task automatic do_reset();
    RST_N = 1'b1;
    clear_inputs();
    tick();
    RST_N = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    drive(0, 5'd9, 32'h2, 1'b0);
    #1;
    n_vec++;
    if (acc !== 4'h0) begin
      n_err++; $display("FAIL reset_accept: got %b want %b", acc, 4'h0);
    end
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b0, 5'd0, 32'h0}) begin
      n_err++; $display("FAIL reset_rf: got %b/%0d/%h want 0/0/0", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
    n_vec++;
    if ({pending_mask_o, wb_stall_o} !== 33'h0) begin
      n_err++; $display("FAIL reset_pend_stall: got %h/%b want 0/0", pending_mask_o, wb_stall_o);
    end
    tick();
    RST_N = 1'b0;
    clear_inputs();
    #1;
    n_vec++;
    if (acc !== 4'hF) begin
      n_err++; $display("FAIL release_accept: got %b want %b", acc, 4'hF);
    end
  endtask

  task automatic test_single();
    drive(0, 5'd9, 32'h2, 1'b0);
    #1;
    n_vec++;
    if ({acc[0], pending_mask_o} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL single_t0: got acc=%b pend=%h want 1/0", acc[0], pending_mask_o);
    end
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if ({pending_mask_o, rf_wr_en_o, wb_stall_o} !== {32'h200, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_t1: got pend=%h en=%b stall=%b want 200/0/0",
                        pending_mask_o, rf_wr_en_o, wb_stall_o);
    end
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, pending_mask_o} !==
        {1'b1, 5'd9, 32'h2, 32'h0}) begin
      n_err++; $display("FAIL single_t2: got %b/%0d/%h pend=%h want 1/9/2 pend=0", rf_wr_en_o,
                        rf_wr_idx_o, rf_wr_value_o, pending_mask_o);
    end
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b0, 5'd9, 32'h2}) begin
      n_err++; $display("FAIL single_hold: got %b/%0d/%h want 0/9/2", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
  endtask

  task automatic test_all_four();
    logic [37:0] exp_rf [6];
    logic        exp_stall [6];
    exp_rf[0] = {1'b0, 5'd0, 32'h0};
    exp_rf[1] = {1'b1, 5'd9, 32'h2};
    exp_rf[2] = {1'b1, 5'd20, 32'h12};
    exp_rf[3] = {1'b1, 5'd24, 32'h16};
    exp_rf[4] = {1'b1, 5'd30, 32'h416};
    exp_rf[5] = {1'b0, 5'd30, 32'h416};
    exp_stall[0] = 1'b1; exp_stall[1] = 1'b1; exp_stall[2] = 1'b1;
    exp_stall[3] = 1'b0; exp_stall[4] = 1'b0; exp_stall[5] = 1'b0;
    drive(0, 5'd9, 32'h2, 1'b0);
    drive(1, 5'd20, 32'h12, 1'b0);
    drive(2, 5'd24, 32'h16, 1'b0);
    drive(3, 5'd30, 32'h416, 1'b0);
    #1;
    n_vec++;
    if (acc !== 4'hF) begin
      n_err++; $display("FAIL all4_accept: got %b want %b", acc, 4'hF);
    end
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if (pending_mask_o !== 32'h4110_0200) begin
      n_err++; $display("FAIL all4_pending: got %h want %h", pending_mask_o, 32'h4110_0200);
    end
    for (int c = 0; c < 6; c++) begin
      n_vec++;
      if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, wb_stall_o} !== {exp_rf[c], exp_stall[c]})
      begin
        n_err++; $display("FAIL all4_cycle%0d: got %b/%0d/%h stall=%b want %h stall=%b", c,
                          rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, wb_stall_o, exp_rf[c],
                          exp_stall[c]);
      end
      tick();
    end
  endtask

  task automatic test_squash_zero();
    drive(2, 5'd26, 32'hFE, 1'b1);
    #1;
    n_vec++;
    if (acc[2] !== 1'b1) begin
      n_err++; $display("FAIL squash_accept: got %b want 1", acc[2]);
    end
    tick();
    clear_inputs();
    drive(1, 5'd0, 32'h5, 1'b0);
    #1;
    n_vec++;
    if ({acc[1], pending_mask_o} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL zero_accept: got acc=%b pend=%h want 1/0", acc[1], pending_mask_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      clear_inputs();
      #1;
      n_vec++;
      if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, pending_mask_o} !==
          {1'b0, 5'd30, 32'h416, 32'h0}) begin
        n_err++; $display("FAIL squash_nowrite%0d: got %b/%0d/%h pend=%h want 0/30/416 pend=0",
                          c, rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, pending_mask_o);
      end
    end
  endtask

  task automatic test_override();
    drive(0, 5'd10, 32'h10, 1'b0);
    #1;
    tick();
    clear_inputs();
    drive(0, 5'd3, 32'hA, 1'b0);
    drive(2, 5'd12, 32'hC, 1'b0);
    #1;
    n_vec++;
    if ({acc[0], pending_mask_o} !== {1'b1, 32'h400}) begin
      n_err++; $display("FAIL ovr_a1: got acc=%b pend=%h want 1/400", acc[0], pending_mask_o);
    end
    tick();
    clear_inputs();
    drive(1, 5'd3, 32'h7, 1'b0);
    #1;
    n_vec++;
    if ({acc, pending_mask_o, wb_stall_o} !== {4'b1110, 32'h1008, 1'b1}) begin
      n_err++; $display("FAIL ovr_a2: got acc=%b pend=%h stall=%b want 1110/1008/1", acc,
                        pending_mask_o, wb_stall_o);
    end
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b1, 5'd10, 32'h10}) begin
      n_err++; $display("FAIL ovr_w10: got %b/%0d/%h want 1/10/10", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, pending_mask_o, wb_stall_o} !==
        {1'b1, 5'd12, 32'hC, 32'h8, 1'b0}) begin
      n_err++; $display("FAIL ovr_a3: got %b/%0d/%h pend=%h stall=%b want 1/12/c pend=8 stall=0",
                        rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, pending_mask_o, wb_stall_o);
    end
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b1, 5'd3, 32'h7}) begin
      n_err++; $display("FAIL ovr_w3: got %b/%0d/%h want 1/3/7", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b0, 5'd3, 32'h7}) begin
      n_err++; $display("FAIL ovr_stale: got %b/%0d/%h want 0/3/7", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
  endtask

  task automatic test_conflict();
    drive(0, 5'd5, 32'hE5, 1'b0);
    drive(3, 5'd5, 32'hD5, 1'b0);
    #1;
    n_vec++;
    if ({acc[3], acc[0]} !== 2'b11) begin
      n_err++; $display("FAIL conf_accept: got %b want 11", {acc[3], acc[0]});
    end
    tick();
    clear_inputs();
    #1;
    n_vec++;
    if ({pending_mask_o, wb_stall_o} !== {32'h20, 1'b0}) begin
      n_err++; $display("FAIL conf_pend: got %h stall=%b want 20/0", pending_mask_o, wb_stall_o);
    end
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b1, 5'd5, 32'hD5}) begin
      n_err++; $display("FAIL conf_write: got %b/%0d/%h want 1/5/d5", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b0, 5'd5, 32'hD5}) begin
      n_err++; $display("FAIL conf_loser: got %b/%0d/%h want 0/5/d5", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 5'd1, 32'h11, 1'b0);
    drive(1, 5'd2, 32'h22, 1'b0);
    drive(2, 5'd4, 32'h44, 1'b0);
    #1;
    tick();
    clear_inputs();
    RST_N = 1'b1;
    #1;
    n_vec++;
    if ({acc, pending_mask_o} !== {4'h0, 32'h16}) begin
      n_err++; $display("FAIL rmid_assert: got acc=%b pend=%h want 0/16", acc, pending_mask_o);
    end
    tick();
    RST_N = 1'b0;
    #1;
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, pending_mask_o, acc} !==
        {1'b0, 5'd0, 32'h0, 32'h0, 4'hF}) begin
      n_err++; $display("FAIL rmid_after: got %b/%0d/%h pend=%h acc=%b want 0/0/0 pend=0 acc=f",
                        rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, pending_mask_o, acc);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (rf_wr_en_o !== 1'b0) begin
        n_err++; $display("FAIL rmid_quiet%0d: got %b want 0", c, rf_wr_en_o);
      end
    end
    drive(0, 5'd6, 32'h66, 1'b0);
    drive(1, 5'd7, 32'h77, 1'b0);
    #1;
    tick();
    clear_inputs();
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b1, 5'd6, 32'h66}) begin
      n_err++; $display("FAIL rmid_first: got %b/%0d/%h want 1/6/66", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
    tick();
    n_vec++;
    if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b1, 5'd7, 32'h77}) begin
      n_err++; $display("FAIL rmid_second: got %b/%0d/%h want 1/7/77", rf_wr_en_o, rf_wr_idx_o,
                        rf_wr_value_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_idx;
    logic [31:0] exp_val;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      if (i < 3) drive(0, 5'(11 + i), 32'(256 + i), 1'b0);
      #1;
      if (i < 3) begin
        n_vec++;
        if (acc[0] !== 1'b1) begin
          n_err++; $display("FAIL b2b_accept%0d: got %b want 1", i, acc[0]);
        end
      end
      if (i >= 2) begin
        exp_idx = 5'(9 + i);
        exp_val = 32'(254 + i);
        n_vec++;
        if ({rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o} !== {1'b1, exp_idx, exp_val}) begin
          n_err++; $display("FAIL b2b_write%0d: got %b/%0d/%h want 1/%0d/%h", i, rf_wr_en_o,
                            rf_wr_idx_o, rf_wr_value_o, exp_idx, exp_val);
        end
      end
      tick();
    end
    n_vec++;
    if (rf_wr_en_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain: got %b want 0", rf_wr_en_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    do_reset();
    test_all_four();
    test_squash_zero();
    test_override();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
